irq_priority_resolver_n: RTL and testbench

//  Synchronous, parametrised priority resolver: successor of the 8-input 8259-style resolver.

---
 rtl/irq_priority_resolver_n.sv | 187 ++++++++++++++++++
 tb/tb_irq_priority_resolver_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_resolver_n.sv
// Parametrised interrupt priority resolver: edge/level capture, masking, fixed or rotating
// priority with in-service nesting, ack/vector handshake and auto/specific/non-specific EOI.
module irq_priority_resolver_n #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ),
    parameter int VEC_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IRQ-1:0]       irq_in,
    input  logic [NUM_IRQ-1:0]       imr,
    input  logic                     level_mode,
    input  logic                     rotate_mode,
    input  logic                     auto_eoi,
    input  logic [VEC_W-IDX_W-1:0]   vec_base,
    input  logic                     ack,
    input  logic                     eoi,
    input  logic                     eoi_specific,
    input  logic [IDX_W-1:0]         eoi_level,
    output logic                     int_req,
    output logic                     vec_valid,
    output logic [VEC_W-1:0]         vec_out,
    output logic [NUM_IRQ-1:0]       irr,
    output logic [NUM_IRQ-1:0]       isr
);

    localparam int RW = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   irr_q, irr_d;
    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 int_req_q, int_req_d;
    logic                 vec_valid_q, vec_valid_d;
    logic [VEC_W-1:0]     vec_out_q, vec_out_d;

    logic [RW-1:0]        rank [NUM_IRQ];
    logic [NUM_IRQ-1:0]   pend;
    logic [NUM_IRQ-1:0]   eoi_dec;
    logic [RW-1:0]        pend_rank, isr_rank;
    logic [IDX_W-1:0]     pend_idx, isr_idx;
    logic                 cand_valid;
    logic                 isr_any;
    logic [NUM_IRQ-1:0]   grant_set, grant_clr, eoi_clr;

    assign pend    = irr_q & ~imr;
    assign isr_any = |isr_q;

    // rank 0 is highest priority; in rotating mode channel ptr+1 holds rank 0
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_rank
            logic [RW-1:0] rot_sum;
            assign rot_sum     = RW'(gi) + RW'(NUM_IRQ) - {1'b0, ptr_q} - RW'(1);
            assign rank[gi]    = !rotate_mode ? RW'(gi)
                               : (rot_sum >= RW'(NUM_IRQ)) ? rot_sum - RW'(NUM_IRQ)
                               : rot_sum;
            assign eoi_dec[gi] = (eoi_level == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        pend_rank = RW'(NUM_IRQ);
        pend_idx  = '0;
        isr_rank  = RW'(NUM_IRQ);
        isr_idx   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && (rank[i] < pend_rank)) begin
                pend_rank = rank[i];
                pend_idx  = IDX_W'(i);
            end
            if (isr_q[i] && (rank[i] < isr_rank)) begin
                isr_rank = rank[i];
                isr_idx  = IDX_W'(i);
            end
        end
        // nesting: only a request strictly above the highest in-service level may interrupt
        cand_valid = (pend_rank < isr_rank);
    end

    always_comb begin
        state_d     = state_q;
        int_req_d   = int_req_q;
        vec_valid_d = 1'b0;
        vec_out_d   = vec_out_q;
        ptr_d       = ptr_q;
        irq_prev_d  = irq_in;
        grant_set   = '0;
        grant_clr   = '0;
        eoi_clr     = '0;

        if (eoi) begin
            if (eoi_specific) begin
                eoi_clr = eoi_dec;
            end else if (isr_any) begin
                eoi_clr = NUM_IRQ'(1) << isr_idx;
                if (rotate_mode) begin
                    ptr_d = isr_idx;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_d   = ST_REQ;
                    int_req_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d     = ST_GRANT;
                    int_req_d   = 1'b0;
                    vec_valid_d = 1'b1;
                    if (cand_valid) begin
                        vec_out_d = {vec_base, pend_idx};
                        grant_clr = NUM_IRQ'(1) << pend_idx;
                        if (auto_eoi) begin
                            if (rotate_mode) begin
                                ptr_d = pend_idx;
                            end
                        end else begin
                            grant_set = NUM_IRQ'(1) << pend_idx;
                        end
                    end else begin
                        vec_out_d = {vec_base, IDX_W'(NUM_IRQ - 1)};
                    end
                end else if (!cand_valid) begin
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end
            end
            ST_GRANT: begin
                // pass through IDLE without a dead cycle so int_req can return at ack+2
                if (cand_valid) begin
                    state_d   = ST_REQ;
                    int_req_d = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase

        irr_d = level_mode ? irq_in : ((irr_q & ~grant_clr) | (irq_in & ~irq_prev_q));
        isr_d = (isr_q & ~eoi_clr) | grant_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            irr_q       <= '0;
            isr_q       <= '0;
            irq_prev_q  <= '0;
            ptr_q       <= IDX_W'(NUM_IRQ - 1);
            int_req_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            irq_prev_q  <= irq_prev_d;
            ptr_q       <= ptr_d;
            int_req_q   <= int_req_d;
            vec_valid_q <= vec_valid_d;
            vec_out_q   <= vec_out_d;
        end
    end

    assign int_req   = int_req_q;
    assign vec_valid = vec_valid_q;
    assign vec_out   = vec_out_q;
    assign irr       = irr_q;
    assign isr       = isr_q;

endmodule

// File: tb/tb_irq_priority_resolver_n.sv
// Directed bench for irq_priority_resolver_n: 8-channel instance for the main scenarios,
// 16-channel instance for the wide masked case.
module tb_irq_priority_resolver_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  irq_in, imr;
    logic        level_mode, rotate_mode, auto_eoi;
    logic [4:0]  vec_base;
    logic        ack, eoi, eoi_specific;
    logic [2:0]  eoi_level;
    logic        int_req, vec_valid;
    logic [7:0]  vec_out, irr, isr;

    logic [15:0] b_irq_in, b_imr;
    logic        b_level_mode, b_rotate_mode, b_auto_eoi;
    logic [3:0]  b_vec_base;
    logic        b_ack, b_eoi, b_eoi_specific;
    logic [3:0]  b_eoi_level;
    logic        b_int_req, b_vec_valid;
    logic [7:0]  b_vec_out;
    logic [15:0] b_irr, b_isr;

    int n_checks = 0;
    int n_fail   = 0;

    irq_priority_resolver_n #(.NUM_IRQ(8), .VEC_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .imr(imr),
        .level_mode(level_mode), .rotate_mode(rotate_mode), .auto_eoi(auto_eoi),
        .vec_base(vec_base), .ack(ack), .eoi(eoi), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .int_req(int_req), .vec_valid(vec_valid),
        .vec_out(vec_out), .irr(irr), .isr(isr)
    );

    irq_priority_resolver_n #(.NUM_IRQ(16), .VEC_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .irq_in(b_irq_in), .imr(b_imr),
        .level_mode(b_level_mode), .rotate_mode(b_rotate_mode), .auto_eoi(b_auto_eoi),
        .vec_base(b_vec_base), .ack(b_ack), .eoi(b_eoi), .eoi_specific(b_eoi_specific),
        .eoi_level(b_eoi_level), .int_req(b_int_req), .vec_valid(b_vec_valid),
        .vec_out(b_vec_out), .irr(b_irr), .isr(b_isr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && int_req !== 1'b1; i++) step();
        check(tag, 32'(int_req), 32'd1);
    endtask

    task automatic do_ack(input string tag, input logic [7:0] exp_vec);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check({tag, "_vvalid"}, 32'(vec_valid), 32'd1);
        check({tag, "_vec"}, 32'(vec_out), 32'(exp_vec));
    endtask

    initial begin
        irq_in = '0; imr = '0; level_mode = 0; rotate_mode = 0; auto_eoi = 0;
        vec_base = 5'h15; ack = 0; eoi = 0; eoi_specific = 0; eoi_level = '0;
        b_irq_in = '0; b_imr = 16'h8000; b_level_mode = 0; b_rotate_mode = 0; b_auto_eoi = 0;
        b_vec_base = 4'hC; b_ack = 0; b_eoi = 0; b_eoi_specific = 0; b_eoi_level = '0;

        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_irr", 32'(irr), 32'h0);
        check("rst_isr", 32'(isr), 32'h0);
        check("rst_int_req", 32'(int_req), 32'd0);
        check("rst_vec_valid", 32'(vec_valid), 32'd0);
        check("rst_vec_out", 32'(vec_out), 32'h0);

        // fixed priority, edge capture: 2 beats 5
        irq_in = 8'h24;
        wait_req("t1_req");
        do_ack("t1", 8'hAA);
        check("t1_isr", 32'(isr), 32'h04);
        check("t1_irr", 32'(irr), 32'h20);
        step();
        check("t1_vvalid_once", 32'(vec_valid), 32'd0);
        step();
        check("t1_no_req", 32'(int_req), 32'd0);

        // nesting: 1 interrupts in-service 2, 5 stays held off
        irq_in = 8'h26;
        wait_req("t2_req");
        do_ack("t2", 8'hA9);
        check("t2_isr", 32'(isr), 32'h06);
        check("t2_irr", 32'(irr), 32'h20);
        step();
        step();
        check("t2_held", 32'(int_req), 32'd0);

        // specific EOI level 2, then non-specific clears 1
        eoi = 1; eoi_specific = 1; eoi_level = 3'd2;
        step();
        eoi = 0;
        check("t5_spec_eoi", 32'(isr), 32'h02);
        eoi = 1; eoi_specific = 0;
        step();
        eoi = 0;
        check("t5_nspec_eoi", 32'(isr), 32'h00);
        wait_req("t5_irq5_req");
        do_ack("t5", 8'hAD);
        check("t5_isr", 32'(isr), 32'h20);
        step();
        eoi = 1;
        step();
        eoi = 0;
        check("t5_clear", 32'(isr), 32'h00);
        eoi = 1;
        step();
        eoi = 0;
        check("eoi_noop", 32'(isr), 32'h00);
        ack = 1;
        step();
        ack = 0;
        check("ack_idle", 32'(vec_valid), 32'd0);

        // rotating priority with auto-EOI
        irq_in = 8'h00;
        step();
        rotate_mode = 1; auto_eoi = 1;
        irq_in = 8'h11;
        wait_req("t3_req");
        do_ack("t3a", 8'hA8);
        check("t3_autoeoi_isr", 32'(isr), 32'h00);
        check("t3_irr", 32'(irr), 32'h10);
        step();
        check("t3_req_ack_plus2", 32'(int_req), 32'd1);
        do_ack("t3b", 8'hAC);
        step();
        irq_in = 8'h00;
        step();
        irq_in = 8'h21;
        wait_req("t3_req2");
        do_ack("t3c", 8'hAD);
        step();
        wait_req("t3_req3");
        do_ack("t3d", 8'hA8);
        step();
        irq_in = 8'h00;

        // level mode: request withdrawn, then spurious ack
        rotate_mode = 0; auto_eoi = 0; level_mode = 1;
        irq_in = 8'h08;
        wait_req("t4_req");
        irq_in = 8'h00;
        step();
        step();
        check("t4_drop", 32'(int_req), 32'd0);
        irq_in = 8'h08;
        wait_req("t4_req2");
        irq_in = 8'h00;
        step();
        do_ack("t4_spur", 8'hAF);
        check("t4_spur_isr", 32'(isr), 32'h00);
        check("t4_spur_int_req", 32'(int_req), 32'd0);
        step();

        // 16 channels, channel 15 masked
        b_irq_in = 16'h8200;
        for (int i = 0; i < 20 && b_int_req !== 1'b1; i++) step();
        check("t6_req", 32'(b_int_req), 32'd1);
        check("t6_irr_pre", 32'(b_irr), 32'h8200);
        b_ack = 1;
        step();
        b_ack = 0;
        check("t6_vvalid", 32'(b_vec_valid), 32'd1);
        check("t6_vec", 32'(b_vec_out), 32'hC9);
        check("t6_isr", 32'(b_isr), 32'h0200);
        check("t6_irr", 32'(b_irr), 32'h8000);
        step();
        step();
        check("t6_masked_idle", 32'(b_int_req), 32'd0);

        // asynchronous reset in the middle of a handshake
        level_mode = 0;
        irq_in = 8'h40;
        wait_req("t7_req");
        ack = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_int_req", 32'(int_req), 32'd0);
        check("t7_async_irr", 32'(irr), 32'h0);
        step();
        ack = 0;
        check("t7_vvalid", 32'(vec_valid), 32'd0);
        check("t7_vec_out", 32'(vec_out), 32'h0);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
